// File: rtl/io_cmd_decoder.sv
// Single-byte command parser between the UART RX FIFO and the UART TX serializer.
// Pops commands, drives sw_rst/start, and answers with an ack byte plus an optional data byte.
module io_cmd_decoder #(
    parameter int RST_PULSE_CYCLES = 16,
    parameter int CMD_WIDTH        = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_fifo_empty,
    input  logic                 rx_fifo_out_valid,
    input  logic [CMD_WIDTH-1:0] rx_fifo_out_data,
    output logic                 rx_fifo_re,
    input  logic                 rx_block_timeout,
    input  logic                 tx_bsy,
    output logic                 send_trig,
    output logic [CMD_WIDTH-1:0] send_data,
    output logic                 sw_rst,
    output logic                 start
);

    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] RD_CMD   = 4'd1;
    localparam logic [3:0] DECODE   = 4'd2;
    localparam logic [3:0] RD_ARG   = 4'd3;
    localparam logic [3:0] WAIT_ARG = 4'd4;
    localparam logic [3:0] TX_TRIG  = 4'd5;
    localparam logic [3:0] TX_HI    = 4'd6;
    localparam logic [3:0] TX_LO    = 4'd7;
    localparam logic [3:0] RST_HOLD = 4'd8;

    localparam logic [CMD_WIDTH-1:0] CMD_SW_RST = 'h01;
    localparam logic [CMD_WIDTH-1:0] CMD_START  = 'h02;
    localparam logic [CMD_WIDTH-1:0] CMD_ECHO   = 'h03;
    localparam logic [CMD_WIDTH-1:0] CMD_STATUS = 'h04;
    localparam logic [CMD_WIDTH-1:0] ACK_BIT    = 'h80;
    localparam logic [CMD_WIDTH-1:0] NACK       = 'hFF;
    localparam logic [7:0]           RST_LOAD   = 8'(RST_PULSE_CYCLES);

    logic [3:0]           state_q, state_d;
    logic [CMD_WIDTH-1:0] cmd_q, cmd_d;
    logic                 pend_q, pend_d;
    logic [CMD_WIDTH-1:0] pend_byte_q, pend_byte_d;
    logic [6:0]           err_cnt_q, err_cnt_d;
    logic [7:0]           rst_cnt_q, rst_cnt_d;
    logic                 rx_fifo_re_q, rx_fifo_re_d;
    logic                 send_trig_q, send_trig_d;
    logic [CMD_WIDTH-1:0] send_data_q, send_data_d;
    logic                 sw_rst_q, sw_rst_d;
    logic                 start_q, start_d;
    logic                 err_inc;

    assign rx_fifo_re = rx_fifo_re_q;
    assign send_trig  = send_trig_q;
    assign send_data  = send_data_q;
    assign sw_rst     = sw_rst_q;
    assign start      = start_q;

    // Saturating error counter, bumped by unknown commands and dropped frames.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_inc && (err_cnt_q != 7'h7F)) begin
            err_cnt_d = err_cnt_q + 7'd1;
        end
    end

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        pend_d       = pend_q;
        pend_byte_d  = pend_byte_q;
        rst_cnt_d    = rst_cnt_q;
        send_data_d  = send_data_q;
        rx_fifo_re_d = 1'b0;
        send_trig_d  = 1'b0;
        sw_rst_d     = 1'b0;
        start_d      = 1'b0;
        err_inc      = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_fifo_empty) begin
                    rx_fifo_re_d = 1'b1;
                    state_d      = RD_CMD;
                end
            end

            RD_CMD: begin
                if (rx_fifo_out_valid) begin
                    cmd_d   = rx_fifo_out_data;
                    // Registered so start is high exactly during the DECODE cycle.
                    start_d = (rx_fifo_out_data == CMD_START);
                    state_d = DECODE;
                end
            end

            DECODE: begin
                if (cmd_q == CMD_ECHO) begin
                    state_d = RD_ARG;
                end else begin
                    state_d = TX_TRIG;
                    case (cmd_q)
                        CMD_SW_RST, CMD_START: begin
                            send_data_d = cmd_q | ACK_BIT;
                        end
                        CMD_STATUS: begin
                            send_data_d = cmd_q | ACK_BIT;
                            pend_d      = 1'b1;
                            pend_byte_d = {1'b0, err_cnt_q};
                        end
                        default: begin
                            send_data_d = NACK;
                            err_inc     = 1'b1;
                        end
                    endcase
                end
            end

            RD_ARG: begin
                if (!rx_fifo_empty) begin
                    rx_fifo_re_d = 1'b1;
                    state_d      = WAIT_ARG;
                end else if (rx_block_timeout) begin
                    err_inc = 1'b1;
                    state_d = IDLE;
                end
            end

            WAIT_ARG: begin
                if (rx_fifo_out_valid) begin
                    pend_d      = 1'b1;
                    pend_byte_d = rx_fifo_out_data;
                    send_data_d = CMD_ECHO | ACK_BIT;
                    state_d     = TX_TRIG;
                end
            end

            TX_TRIG: begin
                if (!tx_bsy) begin
                    send_trig_d = 1'b1;
                    state_d     = TX_HI;
                end
            end

            TX_HI: begin
                if (tx_bsy) begin
                    state_d = TX_LO;
                end
            end

            // send_data may only move here, after the serializer has let go of it.
            TX_LO: begin
                if (!tx_bsy) begin
                    if (pend_q) begin
                        pend_d      = 1'b0;
                        send_data_d = pend_byte_q;
                        state_d     = TX_TRIG;
                    end else if (cmd_q == CMD_SW_RST) begin
                        rst_cnt_d = RST_LOAD;
                        sw_rst_d  = 1'b1;
                        state_d   = RST_HOLD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            RST_HOLD: begin
                if (rst_cnt_q <= 8'd1) begin
                    state_d = IDLE;
                end else begin
                    rst_cnt_d = rst_cnt_q - 8'd1;
                    sw_rst_d  = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cmd_q        <= '0;
            pend_q       <= 1'b0;
            pend_byte_q  <= '0;
            err_cnt_q    <= '0;
            rst_cnt_q    <= '0;
            rx_fifo_re_q <= 1'b0;
            send_trig_q  <= 1'b0;
            send_data_q  <= '0;
            sw_rst_q     <= 1'b0;
            start_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            pend_q       <= pend_d;
            pend_byte_q  <= pend_byte_d;
            err_cnt_q    <= err_cnt_d;
            rst_cnt_q    <= rst_cnt_d;
            rx_fifo_re_q <= rx_fifo_re_d;
            send_trig_q  <= send_trig_d;
            send_data_q  <= send_data_d;
            sw_rst_q     <= sw_rst_d;
            start_q      <= start_d;
        end
    end

endmodule

// File: tb/tb_io_cmd_decoder.sv
// Directed bench for io_cmd_decoder with a FIFO model, a TX serializer model and a TX byte scoreboard.
module tb_io_cmd_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_fifo_empty = 1'b1;
    logic       rx_fifo_out_valid = 1'b0;
    logic [7:0] rx_fifo_out_data = 8'h00;
    logic       rx_fifo_re;
    logic       rx_block_timeout = 1'b0;
    logic       tx_bsy = 1'b0;
    logic       send_trig;
    logic [7:0] send_data;
    logic       sw_rst;
    logic       start;

    io_cmd_decoder #(.RST_PULSE_CYCLES(16), .CMD_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .rx_fifo_empty(rx_fifo_empty), .rx_fifo_out_valid(rx_fifo_out_valid),
        .rx_fifo_out_data(rx_fifo_out_data), .rx_fifo_re(rx_fifo_re),
        .rx_block_timeout(rx_block_timeout), .tx_bsy(tx_bsy),
        .send_trig(send_trig), .send_data(send_data),
        .sw_rst(sw_rst), .start(start)
    );

    always #5 clk = ~clk;

    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    logic       fifo_pend = 1'b0;
    logic [7:0] fifo_pend_data = 8'h00;
    logic       outstanding = 1'b0;
    int         fifo_viol = 0, re_total = 0;
    int         tx_left = 0, tx_hold = 3;
    logic [7:0] tx_cap = 8'h00;
    logic       tx_unstable = 1'b0;
    int         trig_total = 0, trig_busy_viol = 0;
    int         start_total = 0, start_at_trig = 0;
    int         sw_run = 0, sw_last_run = 0, sw_total = 0, sw_bsy_viol = 0;
    int         nvec = 0, nfail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        rx_fifo_empty = 1'b0;
    endtask

    // One cycle: wait for the falling edge, then run every model and monitor.
    task automatic tick();
        @(negedge clk);
        if (rx_fifo_out_valid) outstanding = 1'b0;
        rx_fifo_out_valid = 1'b0;
        if (fifo_pend) begin
            rx_fifo_out_valid = 1'b1;
            rx_fifo_out_data  = fifo_pend_data;
            fifo_pend = 1'b0;
        end
        if (rx_fifo_re) begin
            re_total++;
            if (outstanding || rx_fifo_empty || fifo_q.size() == 0) fifo_viol++;
            if (fifo_q.size() != 0) begin
                fifo_pend_data = fifo_q.pop_front();
                fifo_pend   = 1'b1;
                outstanding = 1'b1;
            end
            rx_fifo_empty = (fifo_q.size() == 0);
        end

        if (tx_left > 0) begin
            if (send_data !== tx_cap) tx_unstable = 1'b1;
            tx_left--;
            if (tx_left == 0) begin
                tx_bsy = 1'b0;
                check("tx_data_stable", 32'(tx_unstable), 32'd0);
            end
        end
        if (send_trig) begin
            if (tx_bsy) trig_busy_viol++;
            trig_total++;
            start_at_trig = start_total;
            check("tx_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("tx_byte", 32'(send_data), 32'(exp_q.pop_front()));
            tx_cap = send_data;
            tx_unstable = 1'b0;
            tx_bsy  = 1'b1;
            tx_left = tx_hold;
        end

        if (start) start_total++;
        if (sw_rst) begin
            sw_run++;
            sw_total++;
            if (tx_bsy) sw_bsy_viol++;
        end else if (sw_run > 0) begin
            sw_last_run = sw_run;
            sw_run = 0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tx_left = 0;
        tx_bsy = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        fifo_pend = 1'b0;
        outstanding = 1'b0;
        rx_fifo_out_valid = 1'b0;
        rx_fifo_empty = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_outputs", {20'd0, rx_fifo_re, send_trig, sw_rst, start, send_data}, 32'd0);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic wait_done(input string tag, input int budget);
        int quiet = 0;
        for (int i = 0; i < budget && quiet < 6; i++) begin
            tick();
            if (exp_q.size() == 0 && fifo_q.size() == 0 && !fifo_pend && !rx_fifo_out_valid &&
                tx_left == 0 && !sw_rst && !rx_fifo_re && !send_trig)
                quiet++;
            else
                quiet = 0;
        end
        check(tag, 32'(quiet >= 6), 32'd1);
    endtask

    initial begin
        int re0, st0, sw0, tr0, found;

        // STATUS after reset, plus a stray timeout in IDLE that must be ignored.
        do_reset();
        re0 = re_total;
        rx_block_timeout = 1'b1; tick(); rx_block_timeout = 1'b0;
        push(8'h04); exp_q.push_back(8'h84); exp_q.push_back(8'h00);
        wait_done("status_drain", 300);
        check("status_one_re", 32'(re_total - re0), 32'd1);

        // SW_RST: ack, then a 16-cycle sw_rst pulse, never during TX.
        st0 = start_total; sw_last_run = 0;
        push(8'h01); exp_q.push_back(8'h81);
        wait_done("swrst_drain", 300);
        check("swrst_pulse_len", 32'(sw_last_run), 32'd16);
        check("swrst_no_start", 32'(start_total - st0), 32'd0);

        // START: one start cycle before the ack trigger.
        st0 = start_total; sw0 = sw_total;
        push(8'h02); exp_q.push_back(8'h82);
        wait_done("start_drain", 300);
        check("start_count", 32'(start_total - st0), 32'd1);
        check("start_before_trig", 32'(start_at_trig - st0), 32'd1);
        check("start_no_swrst", 32'(sw_total - sw0), 32'd0);

        // ECHO, then a truncated ECHO killed by the timeout, then STATUS sees err_cnt=1.
        push(8'h03); push(8'h5A); exp_q.push_back(8'h83); exp_q.push_back(8'h5A);
        wait_done("echo_drain", 300);
        tr0 = trig_total;
        push(8'h03);
        repeat (8) tick();
        rx_block_timeout = 1'b1; tick(); rx_block_timeout = 1'b0;
        wait_done("drop_drain", 100);
        check("drop_no_tx", 32'(trig_total - tr0), 32'd0);
        push(8'h04); exp_q.push_back(8'h84); exp_q.push_back(8'h01);
        wait_done("status_err1", 300);

        // Burst behind a slow serializer; bytes queue in the FIFO meanwhile.
        do_reset();
        tx_hold = 90;
        push(8'h7E); push(8'h04); push(8'h03); push(8'hC3);
        exp_q.push_back(8'hFF); exp_q.push_back(8'h84); exp_q.push_back(8'h01);
        exp_q.push_back(8'h83); exp_q.push_back(8'hC3);
        repeat (100) tick();
        rx_block_timeout = 1'b1; tick(); rx_block_timeout = 1'b0;
        wait_done("burst_drain", 1200);
        tx_hold = 3;

        // Reset during RST_HOLD: sw_rst must drop on the first reset cycle.
        push(8'h01); exp_q.push_back(8'h81);
        found = 0;
        for (int i = 0; i < 300 && found == 0; i++) begin
            tick();
            if (sw_rst) found = 1;
        end
        check("hold_reached", 32'(found), 32'd1);
        repeat (3) tick();
        do_reset();
        push(8'h04); exp_q.push_back(8'h84); exp_q.push_back(8'h00);
        wait_done("after_hold_rst", 300);

        // Reset between send_trig and tx_bsy rising.
        push(8'h04); exp_q.push_back(8'h84); exp_q.push_back(8'h00);
        found = 0;
        for (int i = 0; i < 300 && found == 0; i++) begin
            tick();
            if (trig_total > 0 && send_trig) found = 1;
        end
        check("trig_reached", 32'(found), 32'd1);
        do_reset();
        push(8'h04); exp_q.push_back(8'h84); exp_q.push_back(8'h00);
        wait_done("after_tx_rst", 300);

        check("fifo_rule", 32'(fifo_viol), 32'd0);
        check("trig_while_busy", 32'(trig_busy_viol), 32'd0);
        check("swrst_during_tx", 32'(sw_bsy_viol), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
